input_vc_buffer: RTL and testbench
==================================

// Module: input_vc_buffer
// PURPOSE
//  Input-port flit storage and VC arbitration stage; sits directly upstream of the port controller.
//  Holds one FIFO per virtual channel, writes flits arriving on the link, and picks one non-empty VC round-robin.
//  Presents that VC's head flit to the controller, pops it on the controller's clear, and returns one credit upstream per pop.
// PARAMETERS
//  FLIT_WIDTH  16  flit width in bits (type [3:2], seq [6:4], route info [10:7])
//  NUM_VC      4   virtual channels; fixed at 4 to match the controller's 2-bit VC select
//  VC_DEPTH    4   flits per VC FIFO; power of 2, >=2
// PORTS
//  clk           in   1           clock
//  rst           in   1           reset, asynchronous, active-low
//  in_flit       in   FLIT_WIDTH  incoming link flit
//  in_valid      in   1           in_flit valid this cycle
//  in_vc         in   2           target VC of in_flit
//  ready_i       in   1           controller idle/done, can accept a new grant
//  clear_i       in   1           controller finished the current flit; pop it
//  arb_valid     out  1           grant pulse to the controller
//  sel_vc        out  2           granted VC index
//  vc_selected   out  1           head flit of sel_vc is valid on read_o
//  read_o        out  FLIT_WIDTH  head flit of sel_vc
//  credit_valid  out  1           one credit returned upstream
//  credit_vc     out  2           VC of the returned credit
//  vc_empty      out  NUM_VC      per-VC empty flags
//  overflow_err  out  1           sticky flag: a write hit a full VC
// BEHAVIOUR
//  Reset: all FIFOs empty; rr pointer = 0; state IDLE.
//    Outputs after reset: arb_valid=0, sel_vc=0, vc_selected=0, read_o=0, credit_valid=0, credit_vc=0, vc_empty=all 1s, overflow_err=0.
//  Reset mid-operation discards all stored flits and returns no credits for them.
//  Write path:
//    in_valid writes in_flit to FIFO[in_vc] at the clock edge.
//    Write to a full VC: flit dropped, overflow_err set and held until reset.
//  Arbiter FSM (states IDLE, GRANT, SELECT, BUSY; arb_valid, sel_vc, vc_selected are registered):
//    IDLE:   if ready_i and any VC is non-empty, pick the first non-empty VC from rr+1 upward (wrapping modulo 4); go to GRANT.
//    GRANT:  arb_valid=1 for one cycle, sel_vc = winner; go to SELECT.
//    SELECT: vc_selected=1 for one cycle; go to BUSY.
//    BUSY:   hold sel_vc; wait for clear_i.
//            On clear_i: pop FIFO[sel_vc]; pulse credit_valid=1 with credit_vc=sel_vc in the next cycle; rr = sel_vc; go to IDLE.
//    read_o = head of FIFO[sel_vc], combinational; it is stable from SELECT until the pop.
//  Latency: a flit written into an empty block at cycle N gives arb_valid at N+2 and vc_selected at N+3 (when ready_i is high).
//  clear_i is ignored outside BUSY. ready_i is sampled only in IDLE.
//  A write and a pop on the same VC in the same cycle are both performed; occupancy is unchanged and a full FIFO stays legal.
//  Occupancy counters are log2(VC_DEPTH)+1 bits wide; read and write pointers wrap modulo VC_DEPTH.
// CONFIGURATION
//  PKT_LOCK_EN defined:
//    After a header (type 00) is popped, IDLE re-grants the same VC, ignoring rr, until a tail (type 10) from that VC is popped.
//    If the locked VC is empty, the FSM waits in IDLE.
//  PKT_LOCK_EN undefined: plain per-flit round-robin; flits from different VCs may interleave.
// STRUCTURE
//  Shared package noc_pkg:
//    flit field positions: TYPE [3:2], SEQ [6:4], ROUTE [10:7].
//    type codes: HEADER=2'b00, BODY=2'b01, TAIL=2'b10.
//    FSM state encoding.
//  Sub-module vc_fifo: single-VC synchronous FIFO (wr, rd, full, empty, head, count), instantiated NUM_VC times.
// TESTING
//  1. One header on VC2, ready_i=1: arb_valid at +2, vc_selected at +3, sel_vc=2, read_o=flit; clear_i gives credit_vc=2 and vc_empty[2]=1.
//  2. Flits on VC0, VC1 and VC3 with rr=0: grant order 1, 3, 0; exactly three credits returned, in that order.
//  3. Write 5 flits to VC1 with VC_DEPTH=4: 5th flit dropped, overflow_err=1 and stays 1; 4 flits drain in order.
//  4. VC0 full while clear_i pops VC0 and in_valid writes VC0 in the same cycle: no overflow, count stays 4, FIFO order preserved.
//  5. PKT_LOCK_EN: header, body, tail on VC0 interleaved with traffic on VC1: all three VC0 flits are granted before any VC1 flit.
//  6. Assert rst in BUSY with flits queued: all outputs at reset values next cycle, vc_empty=4'b1111, no credit pulse.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field positions, flit type codes, arbiter state
// encoding and the round-robin pick helper used by the input VC buffer.
package noc_pkg;

  localparam int TYPE_LSB  = 2;
  localparam int TYPE_MSB  = 3;
  localparam int SEQ_LSB   = 4;
  localparam int SEQ_MSB   = 6;
  localparam int ROUTE_LSB = 7;
  localparam int ROUTE_MSB = 10;

  typedef enum logic [1:0] {
    HEADER = 2'b00,
    BODY   = 2'b01,
    TAIL   = 2'b10
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    SELECT = 2'b10,
    BUSY   = 2'b11
  } arb_state_e;

  function automatic flit_type_e flit_type(input logic [TYPE_MSB:0] low_bits);
    return flit_type_e'(low_bits[TYPE_MSB:TYPE_LSB]);
  endfunction

  // Returns {found, vc}: first non-empty VC scanning last+1, last+2, ... wrapping.
  function automatic logic [2:0] rr_pick(input logic [3:0] empty, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!res[2] && !empty[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel synchronous FIFO. A simultaneous write and read on a
// full FIFO is accepted, keeping occupancy constant.
module vc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// Input-port flit storage with round-robin VC arbitration toward the port controller.
// Optional packet locking (keep granting one VC from header to tail) is enabled by PKT_LOCK_EN.
module input_vc_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 16,
  parameter int NUM_VC     = 4,
  parameter int VC_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  input  logic [1:0]            in_vc,
  input  logic                  ready_i,
  input  logic                  clear_i,
  output logic                  arb_valid,
  output logic [1:0]            sel_vc,
  output logic                  vc_selected,
  output logic [FLIT_WIDTH-1:0] read_o,
  output logic                  credit_valid,
  output logic [1:0]            credit_vc,
  output logic [NUM_VC-1:0]     vc_empty,
  output logic                  overflow_err
);

  localparam int CNT_W = $clog2(VC_DEPTH) + 1;

  logic [NUM_VC-1:0]     fifo_wr;
  logic [NUM_VC-1:0]     fifo_rd;
  logic [NUM_VC-1:0]     fifo_full;
  logic [NUM_VC-1:0]     fifo_empty;
  logic [FLIT_WIDTH-1:0] fifo_head  [NUM_VC];
  logic [CNT_W-1:0]      fifo_count [NUM_VC];

  arb_state_e state;
  arb_state_e state_nx;
  logic [1:0] rr;
  logic [1:0] vc_nx;
  logic [2:0] pick;
  logic       pop;
  logic       wr_drop;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign fifo_wr[v] = in_valid && (in_vc == 2'(v));
    assign fifo_rd[v] = pop && (sel_vc == 2'(v));

    vc_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (VC_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (fifo_wr[v]),
      .wr_data (in_flit),
      .rd      (fifo_rd[v]),
      .full    (fifo_full[v]),
      .empty   (fifo_empty[v]),
      .head    (fifo_head[v]),
      .count   (fifo_count[v])
    );
  end

  assign pop      = (state == BUSY) && clear_i;
  assign wr_drop  = in_valid && fifo_full[in_vc] && !fifo_rd[in_vc];
  assign vc_empty = fifo_empty;
  assign pick     = rr_pick(fifo_empty, rr);

  // Storage is never reset, so an empty VC presents zero instead of stale data.
  assign read_o = (fifo_count[sel_vc] != '0) ? fifo_head[sel_vc] : '0;

`ifdef PKT_LOCK_EN
  logic       lock;
  logic [1:0] lock_vc;
  flit_type_e pop_type;

  assign pop_type = flit_type(read_o[TYPE_MSB:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock    <= 1'b0;
      lock_vc <= '0;
    end else if (pop) begin
      if (pop_type == HEADER) begin
        lock    <= 1'b1;
        lock_vc <= sel_vc;
      end else if (pop_type == TAIL) begin
        lock    <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    state_nx = state;
    vc_nx    = sel_vc;
    case (state)
      IDLE: begin
`ifdef PKT_LOCK_EN
        if (lock) begin
          if (ready_i && !fifo_empty[lock_vc]) begin
            state_nx = GRANT;
            vc_nx    = lock_vc;
          end
        end else
`endif
        if (ready_i && pick[2]) begin
          state_nx = GRANT;
          vc_nx    = pick[1:0];
        end
      end
      GRANT:   state_nx = SELECT;
      SELECT:  state_nx = BUSY;
      BUSY:    if (clear_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Arbiter state and registered controller handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr           <= '0;
      arb_valid    <= 1'b0;
      vc_selected  <= 1'b0;
      sel_vc       <= '0;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_nx;
      arb_valid    <= (state_nx == GRANT);
      vc_selected  <= (state_nx == SELECT);
      sel_vc       <= vc_nx;
      credit_valid <= pop;
      if (pop) begin
        credit_vc <= sel_vc;
        rr        <= sel_vc;
      end
      if (wr_drop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Self-checking bench for input_vc_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the VC buffer and arbiter.
module tb_input_vc_buffer;

  localparam int FW    = 16;
  localparam int NV    = 4;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_GRANT = 1, P_SELECT = 2, P_BUSY = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_vc = '0;
  logic          ready_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          arb_valid;
  logic [1:0]    sel_vc;
  logic          vc_selected;
  logic [FW-1:0] read_o;
  logic          credit_valid;
  logic [1:0]    credit_vc;
  logic [NV-1:0] vc_empty;
  logic          overflow_err;

  always #5 clk = ~clk;

  input_vc_buffer #(.FLIT_WIDTH(FW), .NUM_VC(NV), .VC_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .ready_i      (ready_i),
    .clear_i      (clear_i),
    .arb_valid    (arb_valid),
    .sel_vc       (sel_vc),
    .vc_selected  (vc_selected),
    .read_o       (read_o),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .vc_empty     (vc_empty),
    .overflow_err (overflow_err)
  );

  // Reference model: per-VC queues, last-served VC, sticky overflow, controller phase
  logic [FW-1:0] mq [NV][$];
  int            m_rr;
  bit            m_ovf;
  int            phase;
  int            cur_vc;
  bit            m_lock;
  int            m_lock_vc;

  int            checks = 0;
  int            failures = 0;
  int            obs_grants [$];
  int            obs_credits [$];
  logic [FW-1:0] obs_flits [$];

  function automatic logic [FW-1:0] mk(input logic [1:0] t);
    logic [FW-1:0] f;
    f = FW'($urandom);
    f[3:2] = t;
    return f;
  endfunction

  function automatic int model_pick();
    int v;
    if (m_lock) return (mq[m_lock_vc].size() != 0) ? m_lock_vc : -1;
    for (int i = 1; i <= NV; i++) begin
      v = (m_rr + i) % NV;
      if (mq[v].size() != 0) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mq[v].delete();
    m_rr = 0; m_ovf = 0; phase = P_IDLE; cur_vc = 0; m_lock = 0; m_lock_vc = 0;
    obs_grants.delete(); obs_credits.delete(); obs_flits.delete();
  endtask

  // Advance one clock, compare DUT against the model, then apply the edge to the model.
  task automatic step();
    int            want;
    bit            popped;
    logic [1:0]    ptype;
    logic [FW-1:0] exp_head;
    logic [NV-1:0] exp_empty;
    @(posedge clk); #1;
    want = -1;
    if (phase == P_IDLE && ready_i) want = model_pick();
    checks++;
    if (arb_valid !== (want >= 0)) begin
      failures++; $display("FAIL arb_valid: got %b expected %b", arb_valid, want >= 0);
    end
    if (arb_valid === 1'b1) obs_grants.push_back(int'(sel_vc));
    if (want >= 0) begin
      checks++;
      if (sel_vc !== 2'(want)) begin
        failures++; $display("FAIL grant_vc: got %0d expected %0d", sel_vc, want);
      end
      cur_vc = want;
    end
    popped = 0;
    if (phase == P_BUSY && clear_i && mq[cur_vc].size() != 0) begin
      ptype = mq[cur_vc][0][3:2];
      void'(mq[cur_vc].pop_front());
      popped = 1;
      m_rr = cur_vc;
`ifdef PKT_LOCK_EN
      if (ptype == 2'b00) begin m_lock = 1; m_lock_vc = cur_vc; end
      else if (ptype == 2'b10) m_lock = 0;
`else
      if (ptype == 2'b11) m_lock = 0;
`endif
    end
    if (in_valid) begin
      if (mq[in_vc].size() < DEPTH) mq[in_vc].push_back(in_flit);
      else m_ovf = 1;
    end
    checks++;
    if (credit_valid !== popped) begin
      failures++; $display("FAIL credit_valid: got %b expected %b", credit_valid, popped);
    end
    if (credit_valid === 1'b1) obs_credits.push_back(int'(credit_vc));
    if (popped) begin
      checks++;
      if (credit_vc !== 2'(cur_vc)) begin
        failures++; $display("FAIL credit_vc: got %0d expected %0d", credit_vc, cur_vc);
      end
    end
    case (phase)
      P_IDLE:   if (want >= 0) phase = P_GRANT;
      P_GRANT:  phase = P_SELECT;
      P_SELECT: phase = P_BUSY;
      default:  if (clear_i) phase = P_IDLE;
    endcase
    checks++;
    if (vc_selected !== (phase == P_SELECT)) begin
      failures++; $display("FAIL vc_selected: got %b expected %b", vc_selected, phase == P_SELECT);
    end
    if (phase == P_SELECT || phase == P_BUSY) begin
      exp_head = (mq[cur_vc].size() != 0) ? mq[cur_vc][0] : '0;
      checks++;
      if (sel_vc !== 2'(cur_vc) || read_o !== exp_head) begin
        failures++;
        $display("FAIL head: got vc %0d flit %h expected vc %0d flit %h", sel_vc, read_o, cur_vc, exp_head);
      end
      if (phase == P_SELECT) obs_flits.push_back(read_o);
    end
    for (int v = 0; v < NV; v++) exp_empty[v] = (mq[v].size() == 0);
    checks++;
    if (vc_empty !== exp_empty) begin
      failures++; $display("FAIL vc_empty: got %b expected %b", vc_empty, exp_empty);
    end
    checks++;
    if (overflow_err !== m_ovf) begin
      failures++; $display("FAIL overflow_err: got %b expected %b", overflow_err, m_ovf);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; clear_i = 1'b0; ready_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic run_ctrl(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      ready_i  = rdy;
      clear_i  = (phase == P_BUSY);
      step();
    end
    clear_i = 1'b0;
  endtask

  task automatic write_flit(input int vc, input logic [FW-1:0] f);
    in_valid = 1'b1; in_vc = 2'(vc); in_flit = f; clear_i = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (phase != P_BUSY && n < 20) begin
      in_valid = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
      step();
      n++;
    end
    checks++;
    if (phase != P_BUSY) begin
      failures++; $display("FAIL %s_timeout: got no BUSY after %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (arb_valid !== 1'b0)    begin failures++; $display("FAIL rst_arb_valid: got %b expected 0", arb_valid); end
    checks++; if (sel_vc !== 2'd0)       begin failures++; $display("FAIL rst_sel_vc: got %0d expected 0", sel_vc); end
    checks++; if (vc_selected !== 1'b0)  begin failures++; $display("FAIL rst_vc_selected: got %b expected 0", vc_selected); end
    checks++; if (read_o !== '0)         begin failures++; $display("FAIL rst_read_o: got %h expected 0", read_o); end
    checks++; if (credit_valid !== 1'b0) begin failures++; $display("FAIL rst_credit_valid: got %b expected 0", credit_valid); end
    checks++; if (credit_vc !== 2'd0)    begin failures++; $display("FAIL rst_credit_vc: got %0d expected 0", credit_vc); end
    checks++; if (vc_empty !== 4'hF)     begin failures++; $display("FAIL rst_vc_empty: got %b expected 1111", vc_empty); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b expected 0", overflow_err); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_ctrl(2, 1'b1);
  endtask

  task automatic test_single_header();
    logic [FW-1:0] f;
    apply_reset();
    f = mk(2'b00);
    ready_i = 1'b1;
    write_flit(2, f);
    step();
    checks++; if (arb_valid !== 1'b1) begin failures++; $display("FAIL single_arb_latency: got %b expected 1", arb_valid); end
    checks++; if (sel_vc !== 2'd2)    begin failures++; $display("FAIL single_sel_vc: got %0d expected 2", sel_vc); end
    step();
    checks++; if (vc_selected !== 1'b1) begin failures++; $display("FAIL single_sel_latency: got %b expected 1", vc_selected); end
    checks++; if (read_o !== f)         begin failures++; $display("FAIL single_read_o: got %h expected %h", read_o, f); end
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++; if (credit_valid !== 1'b1 || credit_vc !== 2'd2) begin
      failures++; $display("FAIL single_credit: got %b/%0d expected 1/2", credit_valid, credit_vc);
    end
    checks++; if (vc_empty[2] !== 1'b1) begin failures++; $display("FAIL single_empty: got %b expected 1", vc_empty[2]); end
  endtask

  task automatic test_rr_order();
    int exp_order [3];
    exp_order = '{1, 3, 0};
    apply_reset();
    write_flit(0, mk(2'b01));
    write_flit(1, mk(2'b01));
    write_flit(3, mk(2'b01));
    obs_grants.delete(); obs_credits.delete();
    run_ctrl(25, 1'b1);
    checks++;
    if (obs_grants.size() != 3 || obs_credits.size() != 3) begin
      failures++; $display("FAIL rr_count: got grants %0d credits %0d expected 3 3", obs_grants.size(), obs_credits.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_grants.size() || i >= obs_credits.size() ||
          obs_grants[i] != exp_order[i] || obs_credits[i] != exp_order[i]) begin
        failures++; $display("FAIL rr_order[%0d]: got missing or wrong vc expected %0d", i, exp_order[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] f [5];
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      f[i] = mk(2'b01);
      write_flit(1, f[i]);
    end
    step();
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    obs_flits.delete(); obs_credits.delete();
    run_ctrl(35, 1'b1);
    checks++;
    if (obs_flits.size() != 4 || obs_credits.size() != 4) begin
      failures++; $display("FAIL ovf_drain_count: got %0d flits %0d credits expected 4 4", obs_flits.size(), obs_credits.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_flits.size() || obs_flits[i] !== f[i]) begin
        failures++; $display("FAIL ovf_order[%0d]: got wrong or missing flit expected %h", i, f[i]);
      end
    end
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
  endtask

  task automatic test_full_write_pop();
    logic [FW-1:0] f [5];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      f[i] = mk(2'b01);
      write_flit(0, f[i]);
    end
    f[4] = mk(2'b01);
    obs_flits.delete();
    wait_busy("fullwp");
    in_valid = 1'b1; in_vc = 2'd0; in_flit = f[4]; clear_i = 1'b1;
    step();
    in_valid = 1'b0; clear_i = 1'b0;
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL fullwp_ovf: got %b expected 0", overflow_err); end
    run_ctrl(40, 1'b1);
    checks++;
    if (obs_flits.size() != 5) begin
      failures++; $display("FAIL fullwp_count: got %0d expected 5", obs_flits.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs_flits.size() || obs_flits[i] !== f[i]) begin
        failures++; $display("FAIL fullwp_order[%0d]: got wrong or missing flit expected %h", i, f[i]);
      end
    end
  endtask

  task automatic test_reset_busy();
    apply_reset();
    write_flit(0, mk(2'b01));
    write_flit(2, mk(2'b01));
    write_flit(2, mk(2'b01));
    wait_busy("rstbusy");
    clear_i = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (arb_valid !== 1'b0 || vc_selected !== 1'b0 || sel_vc !== 2'd0) begin
      failures++; $display("FAIL rstbusy_arb: got %b %b %0d expected 0 0 0", arb_valid, vc_selected, sel_vc);
    end
    checks++; if (credit_valid !== 1'b0 || credit_vc !== 2'd0) begin
      failures++; $display("FAIL rstbusy_credit: got %b/%0d expected 0/0", credit_valid, credit_vc);
    end
    checks++; if (vc_empty !== 4'hF || read_o !== '0 || overflow_err !== 1'b0) begin
      failures++; $display("FAIL rstbusy_fifo: got %b %h %b expected 1111 0 0", vc_empty, read_o, overflow_err);
    end
    clear_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_ctrl(10, 1'b1);
    checks++; if (obs_credits.size() != 0) begin
      failures++; $display("FAIL rstbusy_no_credit: got %0d credits expected 0", obs_credits.size());
    end
  endtask

`ifdef PKT_LOCK_EN
  task automatic test_pkt_lock();
    int         vcs [6];
    logic [1:0] typs [6];
    int         exp_order [6];
    vcs = '{0, 1, 1, 0, 1, 0};
    typs = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
    exp_order = '{0, 0, 0, 1, 1, 1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      ready_i = 1'b1; in_valid = 1'b1; in_vc = 2'(vcs[i]); in_flit = mk(typs[i]);
      clear_i = (phase == P_BUSY);
      step();
    end
    run_ctrl(60, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= obs_grants.size() || obs_grants[i] != exp_order[i]) begin
        failures++; $display("FAIL lock_order[%0d]: got wrong or missing grant expected %0d", i, exp_order[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      in_vc    = 2'($urandom_range(0, 3));
      in_flit  = mk(2'($urandom_range(0, 2)));
      ready_i  = ($urandom_range(0, 3) != 0);
      clear_i  = ($urandom_range(0, 2) == 0);
      step();
    end
    run_ctrl(200, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_header();
    test_rr_order();
    test_overflow();
    test_full_write_pop();
    test_reset_busy();
`ifdef PKT_LOCK_EN
    test_pkt_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
